// File: rtl/cga_vram_arbiter.sv
// cga_vram_arbiter
//   Shares the single video RAM port between CGA display fetches and CPU
//   memory cycles from the ISA bus. A CPU access is only granted when the
//   sequencer phase hits SLOT_START, and only if the display is not fetching
//   in that cycle. Once granted, the CPU owns the port for SLOT_LEN cycles.
//   ISA wait states are produced on bus_rdy so software sees real contention.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   clkdiv[4:0]         sequencer phase counter
//   disp_req, disp_addr display fetch request and address
//   bus_a, bus_d        CPU offset in the B8000 window, CPU write data
//   bus_memr_l/memw_l   decoded ISA read/write strobes (active low)
//   cpu_dout, bus_rdy   CPU read data (held), ISA ready (low = wait)
//   ram_a, ram_we_l,    VRAM address, write enable (active low),
//   ram_din, ram_dout   write data, read data (valid with address)
//   snow                pulse for each refused display fetch (1-cycle late)
//
// States
//   IDLE      | no CPU cycle in progress; watching for a strobe edge
//   WAIT_SLOT | CPU cycle latched, waiting for clkdiv == SLOT_START
//   ACCESS    | CPU owns the RAM port for SLOT_LEN cycles
//   DONE      | access complete, waiting for both strobes to release

module cga_vram_arbiter #(
    parameter bit         USE_BUS_WAIT = 1'b1,
    parameter logic [4:0] SLOT_START   = 5'd17,
    parameter logic [2:0] SLOT_LEN     = 3'd3,
    parameter bit         VRAM_32K     = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  clkdiv,
    input  logic        disp_req,
    input  logic [18:0] disp_addr,
    input  logic [14:0] bus_a,
    input  logic        bus_memr_l,
    input  logic        bus_memw_l,
    input  logic [7:0]  bus_d,
    output logic [7:0]  cpu_dout,
    output logic        bus_rdy,
    output logic [18:0] ram_a,
    output logic        ram_we_l,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout,
    output logic        snow
);

    typedef enum logic [1:0] {IDLE, WAIT_SLOT, ACCESS, DONE} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic        memr_s;
    logic        memw_s;
    logic        both_q;
    logic [14:0] a_q;
    logic [7:0]  d_q;
    logic        wr_q;
    logic        start;
    logic        a14;

    // A cycle starts on the falling edge of the AND of the synced strobes,
    // so a strobe held low never retriggers.
    assign start = both_q & ~(memr_s & memw_s);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            memr_s   <= 1'b1;
            memw_s   <= 1'b1;
            both_q   <= 1'b1;
            a_q      <= '0;
            d_q      <= '0;
            wr_q     <= 1'b0;
            bus_rdy  <= 1'b1;
            cpu_dout <= 8'h00;
            snow     <= 1'b0;
        end else begin
            memr_s <= bus_memr_l;
            memw_s <= bus_memw_l;
            both_q <= memr_s & memw_s;
            snow   <= (state == ACCESS) && disp_req;

            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= bus_a;
                        d_q   <= bus_d;
                        wr_q  <= ~memw_s;  // write wins if both strobes low
                        state <= WAIT_SLOT;
                        if (USE_BUS_WAIT) bus_rdy <= 1'b0;
                    end
                end
                WAIT_SLOT: begin
                    // Display has priority at grant time; a refused slot
                    // simply waits for the next wrap of clkdiv.
                    if (clkdiv == SLOT_START && !disp_req) begin
                        state <= ACCESS;
                        cnt   <= SLOT_LEN - 3'd1;
                    end
                end
                ACCESS: begin
                    if (cnt == 3'd0) begin
                        if (!wr_q) cpu_dout <= ram_dout;
                        state   <= DONE;
                        bus_rdy <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    if (memr_s & memw_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Port mux is combinational on the registered state so a reset drops
    // the write enable as soon as the state returns to IDLE.
    assign a14 = VRAM_32K ? a_q[14] : 1'b0;

    always_comb begin
        ram_a    = disp_addr;
        ram_we_l = 1'b1;
        ram_din  = d_q;
        if (state == ACCESS) begin
            ram_a    = {4'h0, a14, a_q[13:0]};
            ram_we_l = ~wr_q;
        end
    end

endmodule

// File: tb/tb_cga_vram_arbiter.sv
module tb_cga_vram_arbiter;

    localparam logic [18:0] DISP = 19'h54321;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  clkdiv = 5'd0;
    logic        disp_req;
    logic [18:0] disp_addr;
    logic [14:0] bus_a;
    logic        bus_memr_l, bus_memw_l;
    logic [7:0]  bus_d;

    logic [7:0]  cpu_dout0, cpu_dout1, cpu_dout2;
    logic        bus_rdy0, bus_rdy1, bus_rdy2;
    logic [18:0] ram_a0, ram_a1, ram_a2;
    logic        ram_we_l0, ram_we_l1, ram_we_l2;
    logic [7:0]  ram_din0, ram_din1, ram_din2;
    logic [7:0]  ram_dout0, ram_dout1, ram_dout2;
    logic        snow0, snow1, snow2;

    always #5 clk = ~clk;
    always @(posedge clk) clkdiv <= clkdiv + 5'd1;

    // VRAM contents as seen by reads
    function automatic logic [7:0] fmem(input logic [18:0] a);
        if (a == 19'h00010) return 8'h5A;
        if (a == 19'h04010) return 8'hC3;
        return a[7:0] ^ 8'h3C;
    endfunction

    assign ram_dout0 = fmem(ram_a0);
    assign ram_dout1 = fmem(ram_a1);
    assign ram_dout2 = fmem(ram_a2);

    cga_vram_arbiter #(.USE_BUS_WAIT(1'b1), .VRAM_32K(1'b0)) dut0 (
        .clk(clk), .reset(reset), .clkdiv(clkdiv), .disp_req(disp_req),
        .disp_addr(disp_addr), .bus_a(bus_a), .bus_memr_l(bus_memr_l),
        .bus_memw_l(bus_memw_l), .bus_d(bus_d), .cpu_dout(cpu_dout0),
        .bus_rdy(bus_rdy0), .ram_a(ram_a0), .ram_we_l(ram_we_l0),
        .ram_din(ram_din0), .ram_dout(ram_dout0), .snow(snow0));

    cga_vram_arbiter #(.USE_BUS_WAIT(1'b1), .VRAM_32K(1'b1)) dut1 (
        .clk(clk), .reset(reset), .clkdiv(clkdiv), .disp_req(disp_req),
        .disp_addr(disp_addr), .bus_a(bus_a), .bus_memr_l(bus_memr_l),
        .bus_memw_l(bus_memw_l), .bus_d(bus_d), .cpu_dout(cpu_dout1),
        .bus_rdy(bus_rdy1), .ram_a(ram_a1), .ram_we_l(ram_we_l1),
        .ram_din(ram_din1), .ram_dout(ram_dout1), .snow(snow1));

    cga_vram_arbiter #(.USE_BUS_WAIT(1'b0), .VRAM_32K(1'b0)) dut2 (
        .clk(clk), .reset(reset), .clkdiv(clkdiv), .disp_req(disp_req),
        .disp_addr(disp_addr), .bus_a(bus_a), .bus_memr_l(bus_memr_l),
        .bus_memw_l(bus_memw_l), .bus_d(bus_d), .cpu_dout(cpu_dout2),
        .bus_rdy(bus_rdy2), .ram_a(ram_a2), .ram_we_l(ram_we_l2),
        .ram_din(ram_din2), .ram_dout(ram_dout2), .snow(snow2));

    // Free-running event counters; tests use deltas.
    int rdy0_low = 0;
    int snow0_cnt = 0;
    int rdy2_low = 0;
    int acc2_cnt = 0;
    always @(posedge clk) begin
        if (!bus_rdy0) rdy0_low++;
        if (snow0) snow0_cnt++;
        if (!bus_rdy2) rdy2_low++;
        if (ram_a2 != disp_addr) acc2_cnt++;
    end

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;
    exp_t sb[$];
    int n_checks = 0;
    int n_pass = 0;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL sb_empty observed=%h required=<queued value>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) n_pass++;
            else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cd(input logic [4:0] v);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (clkdiv == v) break;
        end
    endtask

    int r0, s0, r2, a2;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        disp_req   = 1'b0;
        disp_addr  = DISP;
        bus_a      = '0;
        bus_d      = '0;
        bus_memr_l = 1'b1;
        bus_memw_l = 1'b1;
        repeat (3) tick();

        // reset values
        expect_val("rst_rdy", 1);
        expect_val("rst_we", 1);
        expect_val("rst_a", DISP);
        expect_val("rst_dout", 0);
        expect_val("rst_snow", 0);
        chk(bus_rdy0); chk(ram_we_l0); chk(ram_a0); chk(cpu_dout0); chk(snow0);
        reset = 1'b0;

        // CPU write, no display contention
        wait_cd(5'd8);
        r0 = rdy0_low; s0 = snow0_cnt;
        bus_a = 15'h0123; bus_d = 8'hA5; bus_memw_l = 1'b0;
        expect_val("wr_wait_a", DISP);
        expect_val("wr_wait_rdy", 0);
        expect_val("wr_a18", 19'h00123);
        expect_val("wr_we18", 0);
        expect_val("wr_din18", 8'hA5);
        expect_val("wr_we19", 0);
        expect_val("wr_we20", 0);
        expect_val("wr_a20", 19'h00123);
        expect_val("wr_rdy21", 1);
        expect_val("wr_we21", 1);
        expect_val("wr_rdy_low", 11);
        expect_val("wr_snow", 0);
        expect_val("wr_dout", 0);
        wait_cd(5'd17); chk(ram_a0); chk(bus_rdy0);
        tick(); chk(ram_a0); chk(ram_we_l0); chk(ram_din0);
        tick(); chk(ram_we_l0);
        tick(); chk(ram_we_l0); chk(ram_a0);
        tick(); chk(bus_rdy0); chk(ram_we_l0);
        chk(rdy0_low - r0); chk(snow0_cnt - s0); chk(cpu_dout0);
        bus_memw_l = 1'b1;

        // CPU read, 16K vs 32K address mapping
        wait_cd(5'd8);
        bus_a = 15'h4010; bus_memr_l = 1'b0;
        expect_val("rd_a16k", 19'h00010);
        expect_val("rd_a32k", 19'h04010);
        expect_val("rd_we", 1);
        expect_val("rd_dout_early", 0);
        expect_val("rd_dout16k", 8'h5A);
        expect_val("rd_dout32k", 8'hC3);
        expect_val("rd_rdy21", 1);
        wait_cd(5'd18); chk(ram_a0); chk(ram_a1); chk(ram_we_l0);
        wait_cd(5'd20); chk(cpu_dout0);
        tick(); chk(cpu_dout0); chk(cpu_dout1); chk(bus_rdy0);
        bus_memr_l = 1'b1;

        // display holds the first slot: grant deferred one period
        wait_cd(5'd8);
        r0 = rdy0_low;
        bus_a = 15'h0200; bus_d = 8'h3C; bus_memw_l = 1'b0;
        expect_val("def_a18", DISP);
        expect_val("def_rdy18", 0);
        expect_val("def_rdy17b", 0);
        expect_val("def_a18b", 19'h00200);
        expect_val("def_rdy21b", 1);
        expect_val("def_rdy_low", 43);
        wait_cd(5'd17); disp_req = 1'b1;
        tick(); disp_req = 1'b0; chk(ram_a0); chk(bus_rdy0);
        wait_cd(5'd17); chk(bus_rdy0);
        tick(); chk(ram_a0);
        wait_cd(5'd21); chk(bus_rdy0);
        chk(rdy0_low - r0);
        bus_memw_l = 1'b1;

        // display requests throughout ACCESS -> snow
        wait_cd(5'd8);
        s0 = snow0_cnt;
        bus_a = 15'h0055; bus_d = 8'h77; bus_memw_l = 1'b0;
        expect_val("snow_a18", 19'h00055);
        expect_val("snow_a19", 19'h00055);
        expect_val("snow_a20", 19'h00055);
        expect_val("snow_cnt", 3);
        wait_cd(5'd18); disp_req = 1'b1; chk(ram_a0);
        tick(); chk(ram_a0);
        tick(); chk(ram_a0);
        tick(); disp_req = 1'b0;
        repeat (3) tick();
        chk(snow0_cnt - s0);
        bus_memw_l = 1'b1;

        // reset on the second ACCESS cycle of a write
        wait_cd(5'd8);
        bus_a = 15'h0300; bus_d = 8'h11; bus_memw_l = 1'b0;
        expect_val("rmid_we19", 0);
        expect_val("rmid_we", 1);
        expect_val("rmid_rdy", 1);
        expect_val("rmid_a", DISP);
        expect_val("rmid_dout", 0);
        wait_cd(5'd19); chk(ram_we_l0);
        reset = 1'b1; bus_memw_l = 1'b1;
        tick(); chk(ram_we_l0); chk(bus_rdy0); chk(ram_a0); chk(cpu_dout0);
        reset = 1'b0;

        wait_cd(5'd8);
        bus_a = 15'h0301; bus_d = 8'h22; bus_memw_l = 1'b0;
        expect_val("rpost_we", 0);
        expect_val("rpost_din", 8'h22);
        expect_val("rpost_a", 19'h00301);
        expect_val("rpost_rdy", 1);
        wait_cd(5'd18); chk(ram_we_l0); chk(ram_din0); chk(ram_a0);
        wait_cd(5'd21); chk(bus_rdy0);
        bus_memw_l = 1'b1;

        // no-wait instance: back-to-back reads, then a held strobe
        wait_cd(5'd8);
        r2 = rdy2_low; a2 = acc2_cnt;
        bus_a = 15'h0010; bus_memr_l = 1'b0;
        expect_val("nw_dout1", 8'h5A);
        expect_val("nw_dout2", 8'h1C);
        expect_val("nw_dout_hold", 8'h1C);
        expect_val("nw_acc", 6);
        expect_val("nw_rdy_low", 0);
        wait_cd(5'd21); chk(cpu_dout2);
        bus_memr_l = 1'b1;
        wait_cd(5'd24);
        bus_a = 15'h0020; bus_memr_l = 1'b0;
        wait_cd(5'd21); chk(cpu_dout2);
        wait_cd(5'd21); chk(cpu_dout2);
        chk(acc2_cnt - a2); chk(rdy2_low - r2);
        bus_memr_l = 1'b1;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
